noc_traffic_gen: RTL and testbench
==================================

NOC_TRAFFIC_GEN -- requirements
Module: noc_traffic_gen

Interface
REQ-001 SHALL have parameter NUM_OF_NODES, default 8: node count; power of 2, at least 2.
REQ-002 SHALL have parameter NODE_ID, default 0: source node index, less than NUM_OF_NODES.
REQ-003 SHALL have parameter FLIT_DATA_WIDTH, default 16: payload width, at least 16.
REQ-004 SHALL have parameter NUM_OF_VIRTUAL_CHANNELS, default 2: VC count, at least 1.
REQ-005 SHALL have parameter FLITS_PER_PACKET, default 4: flits per packet, 1..255.
REQ-006 SHALL have parameter NUM_OF_PACKETS, default 16: packets per run, 1..65535.
REQ-007 SHALL have parameter GAP_CYCLES, default 2: idle cycles between packets, 0..255.
REQ-008 SHALL have parameter LFSR_SEED, default 16'hACE1: destination LFSR seed, nonzero.
REQ-009 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high.
REQ-010 SHALL have ports: start in 1, run request pulse; busy out 1; done out 1, sticky run-complete.
REQ-011 SHALL have ports: flit_out_valid out 1; flit_out_ready in 1.
REQ-012 SHALL have ports: flit_out_type out 2, where HEAD=01, BODY=00, TAIL=10, HEAD_TAIL=11.
REQ-013 SHALL have ports: flit_out_dest out clog2(NUM_OF_NODES); flit_out_vc out max(1,clog2(NUM_OF_VIRTUAL_CHANNELS)); flit_out_data out FLIT_DATA_WIDTH.
REQ-014 SHALL have port: tx_packet_count out 16, packets fully accepted in the current run.

Function
REQ-015 SHALL implement the FSM IDLE, SEND, GAP, DONE; start is sampled only in IDLE or DONE, and enters SEND with counters cleared and done low.
REQ-016 SHALL hold flit_out_valid high in SEND only; a flit transfers on any cycle with valid and ready both high; a combinational path from ready to valid is forbidden.
REQ-017 SHALL keep all flit_out_* stable while valid is high and ready is low.
REQ-018 SHALL make flit 0 a HEAD, flit FLITS_PER_PACKET-1 a TAIL, and all others BODY; FLITS_PER_PACKET=1 gives HEAD_TAIL.
REQ-019 SHALL set flit_out_data[7:0] to the flit index and the upper bits to the low bits of the packet sequence number, zero-extended.
REQ-020 SHALL hold dest and vc constant for every flit in a packet.
REQ-021 SHALL take dest from the LFSR low bits; if this equals NODE_ID, dest is NODE_ID+1 modulo NUM_OF_NODES. The LFSR advances once per accepted HEAD or HEAD_TAIL flit.
REQ-022 SHALL assign VC round-robin per packet, starting at 0 and wrapping after NUM_OF_VIRTUAL_CHANNELS-1.
REQ-023 SHALL go from SEND to GAP when the TAIL is accepted, incrementing tx_packet_count in the same cycle.
REQ-024 SHALL leave GAP after GAP_CYCLES cycles: to DONE if the count equals NUM_OF_PACKETS, otherwise to SEND. GAP_CYCLES=0 goes directly without an idle cycle, and ready then allows back-to-back flits.
REQ-025 SHALL assert done in DONE and busy in SEND or GAP; start while busy is ignored.
REQ-026 SHALL ignore flit_out_ready while flit_out_valid is low.

Reset
REQ-027 SHALL on reset asynchronously clear to: IDLE; valid, busy, done, type, dest, vc, data and tx_packet_count all 0; LFSR=LFSR_SEED; VC pointer 0.
REQ-028 SHALL on reset mid-packet drop valid immediately; no partial packet is resumed after release.

Configuration
REQ-029 SHALL, with TRAFFIC_GEN_CHECKER_EN defined, add: flit_in_valid in 1, flit_in_type in 2, flit_in_vc in (as flit_out_vc), flit_in_data in FLIT_DATA_WIDTH, rx_packet_count out 16, err out 1.
REQ-030 SHALL have the checker always accept input and keep an expected flit index per VC: HEAD or HEAD_TAIL requires index 0, BODY or TAIL requires the previous index plus 1, and TAIL resets that VC.
REQ-031 SHALL set err on any mismatch or on a HEAD arriving mid-packet; err is sticky until reset. rx_packet_count increments on each TAIL or HEAD_TAIL.
REQ-032 SHALL, without TRAFFIC_GEN_CHECKER_EN, omit the checker ports and logic entirely.

Structure
REQ-033 SHALL place the flit type codes, FSM state encoding and the HEAD/BODY/TAIL helper constants in shared package noc_pkg.
REQ-034 SHALL implement the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, with an advance enable) as sub-module noc_lfsr.

Verification
REQ-035 SHALL cover: ready tied 1, defaults, start pulse -> 16 packets of HEAD,BODY,BODY,TAIL; 2-cycle gaps; VC 0,1,0,1...; done=1; tx_packet_count=16.
REQ-036 SHALL cover: ready low for 5 cycles on a BODY flit -> all outputs stable, and index 1 is sent once after ready rises.
REQ-037 SHALL cover: FLITS_PER_PACKET=1, GAP_CYCLES=0 -> a HEAD_TAIL flit every cycle, data[7:0]=0.
REQ-038 SHALL cover: NODE_ID=3, LFSR forced to produce low bits 3 -> dest=4; dest never equals 3 over 1000 packets.
REQ-039 SHALL cover: reset asserted during flit 2 -> valid=0 asynchronously, and a new start restarts with sequence 0 from LFSR_SEED.
REQ-040 SHALL cover: with TRAFFIC_GEN_CHECKER_EN, output looped to input -> err=0 and rx_packet_count=16; an injected BODY index skip -> err=1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC traffic generator: flit type codes, FSM state
// encoding and head/tail helpers. A flit type is packed as {tail, head}.
package noc_pkg;

    localparam logic [1:0] FLIT_BODY      = 2'b00;
    localparam logic [1:0] FLIT_HEAD      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    localparam int LFSR_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } tg_state_t;

    function automatic logic is_head(input logic [1:0] flit_type_code);
        return flit_type_code[0];
    endfunction

    function automatic logic is_tail(input logic [1:0] flit_type_code);
        return flit_type_code[1];
    endfunction

    function automatic logic [1:0] make_flit_type(input logic is_first, input logic is_last);
        return {is_last, is_first};
    endfunction

endpackage

// File: rtl/noc_lfsr.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, stepping only when
// en is high. Exposes just the low OUT_W bits that the caller consumes.
import noc_pkg::*;

module noc_lfsr #(
    parameter logic [LFSR_WIDTH-1:0] SEED  = 16'hACE1,
    parameter int                    OUT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [OUT_W-1:0] value
);

    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic                  feedback;

    assign feedback = lfsr_state[15] ^ lfsr_state[13] ^ lfsr_state[12] ^ lfsr_state[10];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_state <= SEED;
        end else if (en) begin
            lfsr_state <= {lfsr_state[LFSR_WIDTH-2:0], feedback};
        end
    end

    assign value = lfsr_state[OUT_W-1:0];

endmodule

// File: rtl/noc_traffic_gen.sv
// Packet traffic generator for NoC bring-up. Defining TRAFFIC_GEN_CHECKER_EN
// adds a receive-side flit-order checker with its own ports.
//
// state | meaning
// IDLE  | waiting for start after reset
// SEND  | presenting flits of the current packet (valid high)
// GAP   | idle cycles between packets
// DONE  | run complete, done held until next start
import noc_pkg::*;

module noc_traffic_gen #(
    parameter int              NUM_OF_NODES            = 8,
    parameter int              NODE_ID                 = 0,
    parameter int              FLIT_DATA_WIDTH         = 16,
    parameter int              NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int              FLITS_PER_PACKET        = 4,
    parameter int              NUM_OF_PACKETS          = 16,
    parameter int              GAP_CYCLES              = 2,
    parameter logic [15:0]     LFSR_SEED               = 16'hACE1,
    localparam int             DEST_W = $clog2(NUM_OF_NODES),
    localparam int             VC_W   = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       flit_out_valid,
    input  logic                       flit_out_ready,
    output logic [1:0]                 flit_out_type,
    output logic [DEST_W-1:0]          flit_out_dest,
    output logic [VC_W-1:0]            flit_out_vc,
    output logic [FLIT_DATA_WIDTH-1:0] flit_out_data,
    output logic [15:0]                tx_packet_count
`ifdef TRAFFIC_GEN_CHECKER_EN
    ,
    input  logic                       flit_in_valid,
    input  logic [1:0]                 flit_in_type,
    input  logic [VC_W-1:0]            flit_in_vc,
    input  logic [FLIT_DATA_WIDTH-1:0] flit_in_data,
    output logic [15:0]                rx_packet_count,
    output logic                       err
`endif
);

    localparam int              SEQ_W   = FLIT_DATA_WIDTH - 8;
    localparam logic [DEST_W-1:0] SELF_ID = DEST_W'(NODE_ID);
    localparam logic [VC_W-1:0]   VC_LAST = VC_W'(NUM_OF_VIRTUAL_CHANNELS - 1);

    tg_state_t         state, state_next;
    logic [7:0]        flit_idx;
    logic [7:0]        gap_cnt;
    logic [VC_W-1:0]   vc_ptr;
    logic [DEST_W-1:0] dest_reg, lfsr_dest, head_dest;
    logic              fire, first_flit, last_flit, last_packet;
    logic              run_clear, load_gap;

    assign first_flit  = (flit_idx == 8'd0);
    assign last_flit   = (flit_idx == 8'(FLITS_PER_PACKET - 1));
    assign fire        = (state == ST_SEND) && flit_out_ready;
    assign last_packet = (tx_packet_count == 16'(NUM_OF_PACKETS - 1));
    // Never address ourselves: bump to the next node, wrapping on the power-of-2 count.
    assign head_dest   = (lfsr_dest == SELF_ID) ? SELF_ID + DEST_W'(1) : lfsr_dest;

    noc_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (DEST_W)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (fire && first_flit),
        .value (lfsr_dest)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        run_clear  = 1'b0;
        load_gap   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_SEND;
                    run_clear  = 1'b1;
                end
            end
            ST_SEND: begin
                if (fire && last_flit) begin
                    if (GAP_CYCLES != 0) begin
                        state_next = ST_GAP;
                        load_gap   = 1'b1;
                    end else if (last_packet) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_next = (tx_packet_count == 16'(NUM_OF_PACKETS)) ? ST_DONE : ST_SEND;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_idx        <= '0;
            gap_cnt         <= '0;
            vc_ptr          <= '0;
            dest_reg        <= '0;
            tx_packet_count <= '0;
        end else begin
            if (run_clear) begin
                flit_idx        <= '0;
                vc_ptr          <= '0;
                tx_packet_count <= '0;
            end else if (fire) begin
                if (first_flit) begin
                    dest_reg <= head_dest;
                end
                if (last_flit) begin
                    flit_idx        <= '0;
                    tx_packet_count <= tx_packet_count + 16'd1;
                    vc_ptr          <= (vc_ptr == VC_LAST) ? '0 : vc_ptr + VC_W'(1);
                end else begin
                    flit_idx <= flit_idx + 8'd1;
                end
            end
            // Loaded with GAP_CYCLES-1 so the GAP state lasts exactly GAP_CYCLES cycles.
            if (load_gap) begin
                gap_cnt <= 8'(GAP_CYCLES - 1);
            end else if ((state == ST_GAP) && (gap_cnt != 8'd0)) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    assign flit_out_valid = (state == ST_SEND);
    assign busy           = (state == ST_SEND) || (state == ST_GAP);
    assign done           = (state == ST_DONE);

    // Outputs come only from registers, so they hold steady under backpressure.
    always_comb begin
        flit_out_type = '0;
        flit_out_dest = '0;
        flit_out_vc   = '0;
        flit_out_data = '0;
        if (flit_out_valid) begin
            flit_out_type = make_flit_type(first_flit, last_flit);
            flit_out_dest = first_flit ? head_dest : dest_reg;
            flit_out_vc   = vc_ptr;
            flit_out_data = {SEQ_W'(tx_packet_count), flit_idx};
        end
    end

`ifdef TRAFFIC_GEN_CHECKER_EN
    localparam int VC_SLOTS = 1 << VC_W;

    logic [7:0]          exp_idx [VC_SLOTS];
    logic [VC_SLOTS-1:0] in_pkt;
    logic [7:0]          in_idx;

    assign in_idx = flit_in_data[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_packet_count <= '0;
            err             <= 1'b0;
            in_pkt          <= '0;
            for (int i = 0; i < VC_SLOTS; i++) begin
                exp_idx[i] <= '0;
            end
        end else if (flit_in_valid) begin
            if (is_head(flit_in_type)) begin
                if (in_pkt[flit_in_vc] || (in_idx != 8'd0)) begin
                    err <= 1'b1;
                end
            end else if (!in_pkt[flit_in_vc] || (in_idx != exp_idx[flit_in_vc])) begin
                err <= 1'b1;
            end
            if (is_tail(flit_in_type)) begin
                in_pkt[flit_in_vc]  <= 1'b0;
                exp_idx[flit_in_vc] <= '0;
                rx_packet_count     <= rx_packet_count + 16'd1;
            end else begin
                in_pkt[flit_in_vc]  <= 1'b1;
                exp_idx[flit_in_vc] <= in_idx + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen: default run, backpressure, reset abort,
// single-flit back-to-back traffic with self-avoiding destinations.
`timescale 1ns/1ps

module tb_noc_traffic_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // instance 0: defaults
    logic        start0, rdy0, v0, busy0, done0;
    logic [1:0]  type0;
    logic [2:0]  dest0;
    logic [0:0]  vc0;
    logic [15:0] data0, cnt0;

    // instance 1: single-flit packets, no gap, node 3
    logic        start1, rdy1, v1, busy1, done1;
    logic [1:0]  type1;
    logic [2:0]  dest1;
    logic [0:0]  vc1;
    logic [15:0] data1, cnt1;

`ifdef TRAFFIC_GEN_CHECKER_EN
    logic        inject, inj_valid;
    logic [1:0]  inj_type;
    logic [0:0]  inj_vc;
    logic [15:0] inj_data;
    logic        fin_valid0;
    logic [1:0]  fin_type0;
    logic [0:0]  fin_vc0;
    logic [15:0] fin_data0, rx0, rx1;
    logic        err0, err1;

    assign fin_valid0 = inject ? inj_valid : (v0 & rdy0);
    assign fin_type0  = inject ? inj_type  : type0;
    assign fin_vc0    = inject ? inj_vc    : vc0;
    assign fin_data0  = inject ? inj_data  : data0;
`endif

    noc_traffic_gen u_dut0 (
        .clk             (clk),
        .reset           (rst),
        .start           (start0),
        .busy            (busy0),
        .done            (done0),
        .flit_out_valid  (v0),
        .flit_out_ready  (rdy0),
        .flit_out_type   (type0),
        .flit_out_dest   (dest0),
        .flit_out_vc     (vc0),
        .flit_out_data   (data0),
        .tx_packet_count (cnt0)
`ifdef TRAFFIC_GEN_CHECKER_EN
        ,
        .flit_in_valid   (fin_valid0),
        .flit_in_type    (fin_type0),
        .flit_in_vc      (fin_vc0),
        .flit_in_data    (fin_data0),
        .rx_packet_count (rx0),
        .err             (err0)
`endif
    );

    noc_traffic_gen #(
        .NODE_ID          (3),
        .FLITS_PER_PACKET (1),
        .GAP_CYCLES       (0),
        .NUM_OF_PACKETS   (1000),
        .LFSR_SEED        (16'h0003)
    ) u_dut1 (
        .clk             (clk),
        .reset           (rst),
        .start           (start1),
        .busy            (busy1),
        .done            (done1),
        .flit_out_valid  (v1),
        .flit_out_ready  (rdy1),
        .flit_out_type   (type1),
        .flit_out_dest   (dest1),
        .flit_out_vc     (vc1),
        .flit_out_data   (data1),
        .tx_packet_count (cnt1)
`ifdef TRAFFIC_GEN_CHECKER_EN
        ,
        .flit_in_valid   (1'b0),
        .flit_in_type    (2'b00),
        .flit_in_vc      (1'b0),
        .flit_in_data    (16'h0000),
        .rx_packet_count (rx1),
        .err             (err1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [2:0] map_dest(input logic [15:0] s, input logic [2:0] self_id);
        logic [2:0] low;
        low = s[2:0];
        return (low == self_id) ? low + 3'd1 : low;
    endfunction

    function automatic logic [22:0] ef(input logic [1:0] t, input logic [2:0] d,
                                       input logic vc, input logic [15:0] data);
        return {1'b1, t, d, vc, data};
    endfunction

    logic [22:0] pack0, pack1;
    assign pack0 = {v0, type0, dest0, vc0, data0};
    assign pack1 = {v1, type1, dest1, vc1, data1};

    logic [1:0]  tt [4];
    logic [15:0] m;
    logic [2:0]  d;
    logic [22:0] exp_body;
    int          w;
    int          n_self;

    initial begin
        tt[0] = 2'b01; tt[1] = 2'b00; tt[2] = 2'b00; tt[3] = 2'b10;
        rst = 1'b1;
        start0 = 1'b0; rdy0 = 1'b1;
        start1 = 1'b0; rdy1 = 1'b1;
`ifdef TRAFFIC_GEN_CHECKER_EN
        inject = 1'b0; inj_valid = 1'b0; inj_type = 2'b00; inj_vc = 1'b0; inj_data = 16'h0;
`endif
        repeat (3) @(negedge clk);
        check("reset_state", {v0, busy0, done0, type0, dest0, vc0, data0, cnt0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // default run, ready tied high
        m = 16'hACE1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("busy_running", {busy0, done0}, 2'b10);
        for (int p = 0; p < 16; p++) begin
            for (int f = 0; f < 4; f++) begin
                w = 0;
                while (!v0 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                if (f == 0 && p != 0) check("gap_len", 64'(w), 64'd2);
                if (f == 0) d = map_dest(m, 3'd0);
                check("flit", pack0, ef(tt[f], d, 1'(p % 2), {8'(p), 8'(f)}));
                if (f == 0) m = lfsr_step(m);
                @(negedge clk);
            end
        end
        w = 0;
        while (!done0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("run_done", {done0, busy0, v0}, 3'b100);
        check("tx_count", cnt0, 64'd16);

        // backpressure on a BODY flit
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        d = map_dest(m, 3'd0);
        check("head_run2", pack0, ef(2'b01, d, 1'b0, 16'h0000));
        check("count_cleared", {done0, cnt0}, 64'd0);
        m = lfsr_step(m);
        @(negedge clk);
        rdy0 = 1'b0;
        exp_body = ef(2'b00, d, 1'b0, 16'h0001);
        check("body1", pack0, exp_body);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_stable", pack0, exp_body);
        end
        rdy0 = 1'b1;
        @(negedge clk);
        check("after_stall", pack0, ef(2'b00, d, 1'b0, 16'h0002));

        // reset in the middle of flit 2
        #1 rst = 1'b1;
        #1 check("reset_async", {v0, busy0}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        check("reset_clear", {v0, busy0, done0, type0, dest0, vc0, data0, cnt0}, 64'd0);
        @(negedge clk);
        check("idle_after_reset", {v0, busy0}, 2'b00);
        m = 16'hACE1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("restart_head", pack0, ef(2'b01, map_dest(m, 3'd0), 1'b0, 16'h0000));
        w = 0;
        while (!done0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("restart_done", {done0, cnt0}, {1'b1, 16'd16});

`ifdef TRAFFIC_GEN_CHECKER_EN
        check("rx_count", rx0, 64'd16);
        check("err_clean", err0, 64'd0);
        inject = 1'b1;
        inj_valid = 1'b1; inj_type = 2'b01; inj_vc = 1'b0; inj_data = 16'h0000;
        @(negedge clk);
        check("err_after_head", err0, 64'd0);
        inj_type = 2'b00; inj_data = 16'h0002;
        @(negedge clk);
        inj_valid = 1'b0;
        @(negedge clk);
        check("err_skip", err0, 64'd1);
        inject = 1'b0;
`endif

        // single-flit packets, no gap, self-avoiding destination
        m = 16'h0003;
        n_self = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("dest_bump", dest1, 64'd4);
        for (int p = 0; p < 1000; p++) begin
            d = map_dest(m, 3'd3);
            check("head_tail", pack1, ef(2'b11, d, 1'(p % 2), {8'(p), 8'h00}));
            if (dest1 == 3'd3) n_self++;
            m = lfsr_step(m);
            @(negedge clk);
        end
        check("dest_never_self", 64'(n_self), 64'd0);
        check("done1", {done1, busy1, v1}, 3'b100);
        check("tx_count1", cnt1, 64'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
